// File: rtl/sw_debounce.sv
// sw_debounce: 2-flop synchroniser plus whole-byte debounce FSM with commit pulses.
// Optional DEB_CHG_CNT_EN adds an 8-bit wrapping commit counter on chg_cnt.
module sw_debounce #(
  parameter int              CNT_W           = 24,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 24'd10_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] sw_in,
  output logic [7:0] sw_stable,
  output logic [7:0] sw_rise,
  output logic [7:0] sw_fall,
  output logic       change_stb
`ifdef DEB_CHG_CNT_EN
  ,
  output logic [7:0] chg_cnt
`endif
);

  localparam logic [CNT_W-1:0] LAST = DEBOUNCE_CYCLES - CNT_W'(1);

  typedef enum logic {STABLE, SETTLE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       sync1, sync_q;
  logic [7:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       stable_d;
  logic [7:0]       rise_q, rise_d, fall_q, fall_d;
  logic             stb_q, stb_d;

  // Synchroniser free-runs so the FSM sees current switches the moment ena returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync_q <= '0;
    end else begin
      sync1  <= sw_in;
      sync_q <= sync1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = sw_stable;
    rise_d   = '0;
    fall_d   = '0;
    stb_d    = 1'b0;
    if (ena) begin
      unique case (state_q)
        STABLE: begin
          if (sync_q != sw_stable) begin
            cand_d  = sync_q;
            cnt_d   = '0;
            state_d = SETTLE;
          end
        end
        SETTLE: begin
          if (sync_q != cand_q) begin
            if (sync_q == sw_stable) begin
              state_d = STABLE;
            end else begin
              cand_d = sync_q;
              cnt_d  = '0;
            end
          end else if (cnt_q == LAST) begin
            stable_d = cand_q;
            rise_d   = cand_q & ~sw_stable;
            fall_d   = ~cand_q & sw_stable;
            stb_d    = 1'b1;
            state_d  = STABLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = STABLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= STABLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      sw_stable <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      stb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      sw_stable <= stable_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      stb_q     <= stb_d;
    end
  end

  // Pulses are masked while disabled so a commit never leaks into an ena=0 cycle.
  assign sw_rise    = rise_q & {8{ena}};
  assign sw_fall    = fall_q & {8{ena}};
  assign change_stb = stb_q & ena;

`ifdef DEB_CHG_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     chg_cnt <= '0;
    else if (stb_d) chg_cnt <= chg_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce with DEBOUNCE_CYCLES=4: table-driven commit sequence plus
// hand-written glitch, bounce, enable-freeze and mid-settle reset sequences.
module tb_sw_debounce;

  logic       clk, rst_n, ena;
  logic [7:0] sw_in, sw_stable, sw_rise, sw_fall;
  logic       change_stb;
`ifdef DEB_CHG_CNT_EN
  logic [7:0] chg_cnt;
`endif

  int checks = 0;
  int errors = 0;

  sw_debounce #(.CNT_W(24), .DEBOUNCE_CYCLES(24'd4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sw_in(sw_in),
    .sw_stable(sw_stable), .sw_rise(sw_rise), .sw_fall(sw_fall),
    .change_stb(change_stb)
`ifdef DEB_CHG_CNT_EN
    , .chg_cnt(chg_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] sw;
    logic [7:0] st;
    logic [7:0] ri;
    logic [7:0] fa;
    logic       stb;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clean step: six quiet cycles at the old value, the commit edge, one quiet cycle after.
  task automatic add_seg(input logic [7:0] sw, input logic [7:0] old_v, input logic [7:0] new_v,
                         input logic [7:0] ri, input logic [7:0] fa);
    vec_t v;
    for (int i = 0; i < 6; i++) begin
      v.sw = sw; v.st = old_v; v.ri = 8'h00; v.fa = 8'h00; v.stb = 1'b0;
      tbl.push_back(v);
    end
    v.sw = sw; v.st = new_v; v.ri = ri; v.fa = fa; v.stb = 1'b1;
    tbl.push_back(v);
    v.sw = sw; v.st = new_v; v.ri = 8'h00; v.fa = 8'h00; v.stb = 1'b0;
    tbl.push_back(v);
  endtask

  task automatic run(input int n, input logic [7:0] exp_st, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(name, sw_stable, exp_st);
      chk({name, "_stb"}, change_stb, 1'b0);
    end
  endtask

  task automatic commit(input string name, input logic [7:0] st, input logic [7:0] ri,
                        input logic [7:0] fa);
    @(negedge clk);
    chk({name, "_st"}, sw_stable, st);
    chk({name, "_rise"}, sw_rise, ri);
    chk({name, "_fall"}, sw_fall, fa);
    chk({name, "_stb"}, change_stb, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    add_seg(8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00);
    add_seg(8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF);
    add_seg(8'h01, 8'h00, 8'h01, 8'h01, 8'h00);
    add_seg(8'h80, 8'h01, 8'h80, 8'h80, 8'h01);
    add_seg(8'h01, 8'h80, 8'h01, 8'h01, 8'h80);

    rst_n = 1'b0; ena = 1'b1; sw_in = 8'hFF;
    repeat (10) @(negedge clk);
    chk("rst_stable", sw_stable, 8'h00);
    chk("rst_rise", sw_rise, 8'h00);
    chk("rst_fall", sw_fall, 8'h00);
    chk("rst_stb", change_stb, 1'b0);
`ifdef DEB_CHG_CNT_EN
    chk("rst_chg", chg_cnt, 8'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      sw_in = tbl[i].sw;
      @(negedge clk);
      chk($sformatf("tbl%0d_st", i), sw_stable, tbl[i].st);
      chk($sformatf("tbl%0d_rise", i), sw_rise, tbl[i].ri);
      chk($sformatf("tbl%0d_fall", i), sw_fall, tbl[i].fa);
      chk($sformatf("tbl%0d_stb", i), change_stb, tbl[i].stb);
    end
`ifdef DEB_CHG_CNT_EN
    chk("tbl_chg", chg_cnt, 8'd5);
`endif

    sw_in = 8'h00;
    run(6, 8'h01, "go0");
    commit("go0", 8'h00, 8'h00, 8'h01);

    // Three-cycle glitch never reaches the end of the settle window.
    sw_in = 8'h40;
    run(3, 8'h00, "glitch");
    sw_in = 8'h00;
    run(12, 8'h00, "glitch_after");

    for (int k = 0; k < 6; k++) begin
      sw_in = (k % 2 == 0) ? 8'h08 : 8'h00;
      run(2, 8'h00, "bounce");
    end
    sw_in = 8'h08;
    run(6, 8'h00, "bounce_hold");
    commit("bounce", 8'h08, 8'h08, 8'h00);
    run(8, 8'h08, "bounce_post");

    // Freeze after two SETTLE cycles; resume needs two more edges to commit.
    sw_in = 8'h00;
    run(5, 8'h08, "ena_settle");
    ena = 1'b0;
    run(10, 8'h08, "ena_off");
    ena = 1'b1;
    run(1, 8'h08, "ena_resume");
    commit("ena", 8'h00, 8'h00, 8'h08);
`ifdef DEB_CHG_CNT_EN
    chk("ena_chg", chg_cnt, 8'd8);
`endif

    sw_in = 8'h55;
    run(6, 8'h00, "go55");
    commit("go55", 8'h55, 8'h55, 8'h00);
    sw_in = 8'hAA;
    run(4, 8'h55, "mid_settle");
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_st", sw_stable, 8'h00);
    chk("midrst_rise", sw_rise, 8'h00);
    chk("midrst_fall", sw_fall, 8'h00);
    chk("midrst_stb", change_stb, 1'b0);
`ifdef DEB_CHG_CNT_EN
    chk("midrst_chg", chg_cnt, 8'd0);
`endif
    sw_in = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(10, 8'h00, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
